// File: rtl/data_mem_lsu_if.sv
// data_mem_lsu_if: request/response handshake bundle for the data memory.
// master = MEM stage side, slave = memory side.
interface data_mem_lsu_if #(
  parameter int ADDR_WIDTH = 17
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_addr,
    output req_size, req_unsigned, req_wdata,
    output rsp_ready,
    input  req_ready, rsp_valid,
    input  rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_size, req_unsigned, req_wdata,
    input  rsp_ready,
    output req_ready, rsp_valid,
    output rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_lsu.sv
// data_mem_lsu: RV32 byte/half/word data RAM, valid/ready, in-order rsp.
// DATA_MEM_LSU_MISALIGN_SPLIT_EN splits misaligned half/word accesses.
module data_mem_lsu #(
  parameter int    ADDR_WIDTH = 17,
  parameter int    LATENCY    = 1,
  parameter string INIT_FILE  = ""
) (
  input logic           clk,
  input logic           rst_n,
  data_mem_lsu_if.slave bus
);
  localparam int WA    = ADDR_WIDTH - 2;
  localparam int DEPTH = 1 << WA;
  localparam int QD    = LATENCY + 1;
  localparam int PW    = $clog2(QD);
  localparam int CW    = $clog2(QD + 1);

  typedef enum logic {IDLE, SPLIT} state_t;

  logic [31:0]   mem [DEPTH];
  state_t        state;
  logic [CW-1:0] outstanding;

  logic          fire;
  logic          pop;
  logic [1:0]    off;
  logic [WA-1:0] widx;
  logic          is_half;
  logic          is_word;
  logic          bad_size;
  logic          misal;
  logic          err;
  logic          split;
  logic [7:0]    be_base;
  logic [7:0]    be64;
  logic [63:0]   wd64;

  assign fire     = bus.req_valid && bus.req_ready;
  assign pop      = bus.rsp_valid && bus.rsp_ready;
  assign off      = bus.req_addr[1:0];
  assign widx     = bus.req_addr[ADDR_WIDTH-1:2];
  assign is_half  = bus.req_size == 2'b01;
  assign is_word  = bus.req_size == 2'b10;
  assign bad_size = bus.req_size == 2'b11;
  assign misal    = (is_half && off[0])
                 || (is_word && off != 2'b00);

`ifdef DATA_MEM_LSU_MISALIGN_SPLIT_EN
  assign split = misal;
  assign err   = bad_size;
`else
  assign split = 1'b0;
  assign err   = bad_size || misal;
`endif

  always_comb begin
    be_base = 8'h01;
    unique case (1'b1)
      is_word: be_base = 8'h0f;
      is_half: be_base = 8'h03;
      default: be_base = 8'h01;
    endcase
  end

  // 8-byte window: lanes [3:0] hit word A, [7:4] hit word A+1
  assign be64 = be_base << off;
  assign wd64 = {32'h0, bus.req_wdata} << {off, 3'b000};

  logic [WA-1:0] sp_idx;
  logic [WA-1:0] sp_nxt;
  logic          sp_we;
  logic [1:0]    sp_off;
  logic [1:0]    sp_size;
  logic          sp_uns;
  logic [3:0]    sp_be_hi;
  logic [31:0]   sp_wd_hi;

  assign sp_nxt = sp_idx + WA'(1);

  logic          wr_en;
  logic [WA-1:0] wr_idx;
  logic [3:0]    wr_be;
  logic [31:0]   wr_data;
  logic [WA-1:0] rd_idx;
  logic [31:0]   rd_q;

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = widx;
    wr_be   = be64[3:0];
    wr_data = wd64[31:0];
    if (state == SPLIT) begin
      wr_en   = sp_we;
      wr_idx  = sp_nxt;
      wr_be   = sp_be_hi;
      wr_data = sp_wd_hi;
    end else if (fire && bus.req_we && !err) begin
      wr_en = 1'b1;
    end
  end

  assign rd_idx = (state == SPLIT) ? sp_nxt : widx;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
    rd_q <= mem[rd_idx];
  end

  logic        launch;
  logic        s0_v;
  logic        s0_we;
  logic        s0_err;
  logic [1:0]  s0_off;
  logic [1:0]  s0_size;
  logic        s0_uns;
  logic        s0_split;
  logic [31:0] lo_q;

  assign launch = (state == SPLIT) || (fire && !split);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      outstanding <= '0;
      s0_v        <= 1'b0;
      s0_we       <= 1'b0;
      s0_err      <= 1'b0;
      s0_off      <= '0;
      s0_size     <= '0;
      s0_uns      <= 1'b0;
      s0_split    <= 1'b0;
      lo_q        <= '0;
      sp_idx      <= '0;
      sp_we       <= 1'b0;
      sp_off      <= '0;
      sp_size     <= '0;
      sp_uns      <= 1'b0;
      sp_be_hi    <= '0;
      sp_wd_hi    <= '0;
    end else begin
      outstanding <= outstanding + CW'(fire) - CW'(pop);
      s0_v        <= launch;
      if (state == SPLIT) begin
        state    <= IDLE;
        lo_q     <= rd_q;
        s0_we    <= sp_we;
        s0_err   <= 1'b0;
        s0_off   <= sp_off;
        s0_size  <= sp_size;
        s0_uns   <= sp_uns;
        s0_split <= 1'b1;
      end else if (fire) begin
        s0_we    <= bus.req_we;
        s0_err   <= err;
        s0_off   <= off;
        s0_size  <= bus.req_size;
        s0_uns   <= bus.req_unsigned;
        s0_split <= 1'b0;
        if (split) begin
          state    <= SPLIT;
          sp_idx   <= widx;
          sp_we    <= bus.req_we;
          sp_off   <= off;
          sp_size  <= bus.req_size;
          sp_uns   <= bus.req_unsigned;
          sp_be_hi <= be64[7:4];
          sp_wd_hi <= wd64[63:32];
        end
      end
    end
  end

  logic [63:0] w64;
  logic [31:0] sh;
  logic [31:0] fmt;

  always_comb begin
    w64 = s0_split ? {rd_q, lo_q} : {32'h0, rd_q};
    sh  = 32'(w64 >> {s0_off, 3'b000});
    fmt = '0;
    unique case (s0_size)
      2'b00: fmt = s0_uns ? {24'h0, sh[7:0]}
                          : {{24{sh[7]}}, sh[7:0]};
      2'b01: fmt = s0_uns ? {16'h0, sh[15:0]}
                          : {{16{sh[15]}}, sh[15:0]};
      default: fmt = sh;
    endcase
    if (s0_we || s0_err) fmt = '0;
  end

  logic        out_v;
  logic [31:0] out_data;
  logic        out_err;

  if (LATENCY == 1) begin : g_l1
    assign out_v    = s0_v;
    assign out_data = fmt;
    assign out_err  = s0_err;
  end else begin : g_l2
    logic        s1_v;
    logic [31:0] s1_data;
    logic        s1_err;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_v    <= 1'b0;
        s1_data <= '0;
        s1_err  <= 1'b0;
      end else begin
        s1_v    <= s0_v;
        s1_data <= fmt;
        s1_err  <= s0_err;
      end
    end
    assign out_v    = s1_v;
    assign out_data = s1_data;
    assign out_err  = s1_err;
  end

  // outstanding <= QD guarantees the queue never overflows
  logic [31:0]   q_data [QD];
  logic [QD-1:0] q_err;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] qcnt;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(QD - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (out_v) begin
      q_data[wptr] <= out_data;
      q_err[wptr]  <= out_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      qcnt <= '0;
    end else begin
      if (out_v) wptr <= nxt(wptr);
      if (pop)   rptr <= nxt(rptr);
      qcnt <= qcnt + CW'(out_v) - CW'(pop);
    end
  end

  assign bus.rsp_valid = qcnt != '0;
  assign bus.rsp_rdata = bus.rsp_valid ? q_data[rptr] : '0;
  assign bus.rsp_err   = bus.rsp_valid && q_err[rptr];
  assign bus.req_ready = (outstanding < CW'(QD))
                      && (state == IDLE);
endmodule
